// File: rtl/clk_gate_pkg.sv
// Shared types and defaults for the DHCEN clock-gate sequencer.
package clk_gate_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } clk_gate_state_t;

  localparam int WAKE_CYCLES_DEF    = 16;
  localparam int DRAIN_MIN_DEF      = 4;
  localparam int TIMEOUT_CYCLES_DEF = 4096;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for slow level signals crossing into clk.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;
  logic [WIDTH-1:0] sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Stop/restart sequencer driving the DHCEN ce pin (ce=1 stops clkout).
// Optional idle-wait timeout in DRAIN: define CLK_GATE_IDLE_TIMEOUT_EN.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int WAKE_CYCLES = WAKE_CYCLES_DEF,
  parameter int DRAIN_MIN   = DRAIN_MIN_DEF
`ifdef CLK_GATE_IDLE_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_req,
  input  logic dom_idle,
  output logic gate_ce,
  output logic en_ack,
  output logic busy
`ifdef CLK_GATE_IDLE_TIMEOUT_EN
  , output logic timeout_err
`endif
);

`ifdef CLK_GATE_IDLE_TIMEOUT_EN
  localparam int CNT_MAX = max_int(max_int(WAKE_CYCLES, DRAIN_MIN), TIMEOUT_CYCLES);
`else
  localparam int CNT_MAX = max_int(WAKE_CYCLES, DRAIN_MIN);
`endif
  localparam int CNT_W = $clog2(CNT_MAX) + 1;

  clk_gate_state_t  state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             idle_s;
  logic             timeout_hit;

  sync_2ff #(.WIDTH(1)) u_idle_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (dom_idle),
    .q     (idle_s)
  );

`ifdef CLK_GATE_IDLE_TIMEOUT_EN
  logic [CNT_W-1:0] tcnt;
`endif

  always_comb begin
    nxt         = state;
    cnt_nxt     = cnt;
    timeout_hit = 1'b0;
    case (state)
      ST_OFF: begin
        if (en_req) begin
          nxt     = ST_WAKE;
          cnt_nxt = CNT_W'(WAKE_CYCLES - 1);
        end
      end
      // A falling request cannot abort WAKE; ON will route it to DRAIN.
      ST_WAKE: begin
        if (cnt == '0) nxt = ST_ON;
        else           cnt_nxt = cnt - CNT_W'(1);
      end
      ST_ON: begin
        if (!en_req) begin
          nxt     = ST_DRAIN;
          cnt_nxt = CNT_W'(DRAIN_MIN - 1);
        end
      end
      ST_DRAIN: begin
        if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
        // Clock never stopped, so a returning request skips WAKE.
        if (en_req) begin
          nxt = ST_ON;
        end else if (cnt == '0 && idle_s) begin
          nxt = ST_OFF;
        end
`ifdef CLK_GATE_IDLE_TIMEOUT_EN
        else if (tcnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          nxt         = ST_OFF;
          timeout_hit = 1'b1;
        end
`endif
      end
      default: nxt = ST_OFF;
    endcase
  end

  // Outputs registered from the next state so ce only moves on clk edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_OFF;
      cnt     <= '0;
      gate_ce <= 1'b1;
      en_ack  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= cnt_nxt;
      gate_ce <= (nxt == ST_OFF);
      en_ack  <= (nxt == ST_ON);
      busy    <= (nxt == ST_WAKE) || (nxt == ST_DRAIN);
    end
  end

`ifdef CLK_GATE_IDLE_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ST_DRAIN && nxt == ST_DRAIN) tcnt <= tcnt + CNT_W'(1);
      else                                      tcnt <= '0;
      timeout_err <= timeout_err | timeout_hit;
    end
  end
`endif

endmodule
